// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 fetch/execute sequencer.
package td4_pkg;

  localparam int OPC_W  = 4;
  localparam int IMM_W  = 4;
  localparam int DATA_W = 4;
  localparam int WORD_W = OPC_W + IMM_W;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT
  } state_e;

  typedef enum logic [OPC_W-1:0] {
    ADD_A    = 4'b0000,
    MOV_A_B  = 4'b0001,
    IN_A     = 4'b0010,
    MOV_A_IM = 4'b0011,
    MOV_B_A  = 4'b0100,
    ADD_B    = 4'b0101,
    IN_B     = 4'b0110,
    MOV_B_IM = 4'b0111,
    OUT_B    = 4'b1001,
    OUT_IM   = 4'b1011,
    JNC      = 4'b1110,
    JMP      = 4'b1111
  } opcode_e;

  // Upper nibble of an instruction word viewed as an opcode; unlisted codes act as NOP.
  function automatic opcode_e word_opcode(input logic [WORD_W-1:0] word);
    return opcode_e'(word[WORD_W-1:IMM_W]);
  endfunction

  // Lower nibble of an instruction word (the immediate field).
  function automatic logic [IMM_W-1:0] word_imm(input logic [WORD_W-1:0] word);
    return word[IMM_W-1:0];
  endfunction

endpackage

// File: rtl/td4_alu.sv
// 4-bit adder used by ADD A,Im and ADD B,Im; carry is bit 4 of the 5-bit sum.
module td4_alu
  import td4_pkg::*;
(
  input  logic [DATA_W-1:0] src_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o
);

  assign {carry_o, sum_o} = {1'b0, src_i} + {1'b0, imm_i};

endmodule

// File: rtl/td4_sequencer.sv
// Two-cycle fetch/execute controller for the TD4 CPU with run/step control and
// self-jump halt detection. ROM is combinational and addressed directly by the PC.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter logic [3:0] RESET_PC        = 4'h0,
  parameter bit         HALT_ON_SELFJMP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  output logic [3:0]        rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  input  logic [3:0]        in_port,
  output logic [3:0]        out_port,
  output logic              busy,
  output logic              halted,
  output logic [3:0]        dbg_a,
  output logic [3:0]        dbg_b,
  output logic              dbg_carry
);

  state_e            state_q, state_d;
  logic [3:0]        pc_q, pc_d;
  logic [3:0]        a_q, a_d;
  logic [3:0]        b_q, b_d;
  logic              carry_q, carry_d;
  logic [3:0]        out_q, out_d;
  logic [WORD_W-1:0] ir_q, ir_d;

  opcode_e           opcode;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] alu_src;
  logic [DATA_W-1:0] alu_sum;
  logic              alu_carry;
  logic              halt_det;

  assign opcode   = word_opcode(ir_q);
  assign imm      = word_imm(ir_q);
  assign alu_src  = (opcode == ADD_B) ? b_q : a_q;
  assign halt_det = HALT_ON_SELFJMP && (opcode == JMP) && (imm == pc_q);

  td4_alu u_alu (
    .src_i   (alu_src),
    .imm_i   (imm),
    .sum_o   (alu_sum),
    .carry_o (alu_carry)
  );

  // State register; reset returns to IDLE regardless of where we were.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: run wins over step, HALT is sticky, EXEC decides continue/stop/halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run || step) state_d = FETCH;
      FETCH:   state_d = EXEC;
      EXEC: begin
        if (halt_det) state_d = HALT;
        else if (run) state_d = FETCH;
        else          state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state only.
  always_comb begin
    busy   = (state_q == FETCH) || (state_q == EXEC);
    halted = (state_q == HALT);
  end

  // Datapath next values: latch IR in FETCH, write back everything at the end of EXEC.
  always_comb begin
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    out_d   = out_q;
    ir_d    = ir_q;
    if (state_q == FETCH) begin
      ir_d = rom_data;
    end
    if (state_q == EXEC) begin
      pc_d    = pc_q + 4'd1;
      carry_d = 1'b0;
      case (opcode)
        ADD_A: begin
          a_d     = alu_sum;
          carry_d = alu_carry;
        end
        ADD_B: begin
          b_d     = alu_sum;
          carry_d = alu_carry;
        end
        MOV_A_IM: a_d = imm;
        MOV_B_IM: b_d = imm;
        MOV_A_B:  a_d = b_q;
        MOV_B_A:  b_d = a_q;
        IN_A:     a_d = in_port;
        IN_B:     b_d = in_port;
        OUT_B:    out_d = b_q;
        OUT_IM:   out_d = imm;
        JMP:      pc_d = imm;
        JNC:      if (!carry_q) pc_d = imm;
        default:  ;
      endcase
    end
  end

  // Datapath registers; synchronous reset discards any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      carry_q <= 1'b0;
      out_q   <= 4'h0;
      ir_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      ir_q    <= ir_d;
    end
  end

  assign rom_addr  = pc_q;
  assign out_port  = out_q;
  assign dbg_a     = a_q;
  assign dbg_b     = b_q;
  assign dbg_carry = carry_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// Self-checking bench for td4_sequencer: behavioural ROM plus an instruction-level
// reference model, directed scenarios and randomized programs.
module tb_td4_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       step;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic       busy;
  logic       halted;
  logic [3:0] dbg_a;
  logic [3:0] dbg_b;
  logic       dbg_carry;

  logic [7:0] rom [16];

  int errors = 0;
  int checks = 0;

  // Architectural reference state, one update per instruction.
  int m_pc, m_a, m_b, m_c, m_out;
  bit m_halt;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  td4_sequencer #(
    .RESET_PC        (4'h0),
    .HALT_ON_SELFJMP (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .in_port   (in_port),
    .out_port  (out_port),
    .busy      (busy),
    .halted    (halted),
    .dbg_a     (dbg_a),
    .dbg_b     (dbg_b),
    .dbg_carry (dbg_carry)
  );

  // Watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] dut_vec();
    return {halted, rom_addr, dbg_a, dbg_b, dbg_carry, out_port};
  endfunction

  function automatic logic [17:0] model_vec();
    logic [3:0] pc4, a4, b4, o4;
    pc4 = m_pc[3:0];
    a4  = m_a[3:0];
    b4  = m_b[3:0];
    o4  = m_out[3:0];
    return {m_halt, pc4, a4, b4, (m_c != 0), o4};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_halt = 0;
  endtask

  // Execute one instruction word on the reference state using plain arithmetic.
  task automatic model_exec(input logic [7:0] w, input logic [3:0] pin);
    int op, im, nxt, s, c;
    op  = int'(w[7:4]);
    im  = int'(w[3:0]);
    nxt = (m_pc + 1) % 16;
    c   = 0;
    case (op)
      0:  begin s = m_a + im; m_a = s % 16; c = s / 16; end
      5:  begin s = m_b + im; m_b = s % 16; c = s / 16; end
      3:  m_a = im;
      7:  m_b = im;
      1:  m_a = m_b;
      4:  m_b = m_a;
      2:  m_a = int'(pin);
      6:  m_b = int'(pin);
      9:  m_out = m_b;
      11: m_out = im;
      15: begin nxt = im; if (im == m_pc) m_halt = 1; end
      14: if (m_c == 0) nxt = im;
      default: ;
    endcase
    m_c  = c;
    m_pc = nxt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Run mode for up to n instructions, dropping run during the last EXEC.
  task automatic run_instrs(input int n, input bit rnd_in);
    logic [17:0] exp_v;
    run = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (rom_addr !== m_pc[3:0]) begin
        errors++;
        $display("[TB] FAIL exec_addr: rom_addr=%h expected %h", rom_addr, m_pc[3:0]);
      end
      if (rnd_in) in_port = 4'($urandom_range(0, 15));
      if (i == n - 1) run = 1'b0;
      model_exec(rom[m_pc], in_port);
      tick();
      exp_v = model_vec();
      checks++;
      if (dut_vec() !== exp_v) begin
        errors++;
        $display("[TB] FAIL run_instr: state {halt,pc,a,b,c,out}=%h expected %h", dut_vec(), exp_v);
      end
      if (m_halt) break;
      if (i < n - 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL back_to_back_busy: busy=%b expected 1", busy);
        end
      end
    end
    run = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_end_busy: busy=%b expected 0", busy);
    end
  endtask

  // Single-step one instruction from IDLE.
  task automatic step_instr(input bit rnd_in);
    logic [17:0] exp_v;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    if (rnd_in) in_port = 4'($urandom_range(0, 15));
    model_exec(rom[m_pc], in_port);
    tick();
    exp_v = model_vec();
    checks++;
    if (dut_vec() !== exp_v || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL step_instr: state=%h busy=%b expected %h busy=0", dut_vec(), busy, exp_v);
    end
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int k = 0; k < 16; k++) rom[k] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    checks++;
    if (dut_vec() !== 18'h0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: state=%h busy=%b expected 00000 busy=0", dut_vec(), busy);
    end
  endtask

  task automatic test_add_carry();
    do_reset();
    fill_rom(8'h80);
    rom[0] = 8'h35; rom[1] = 8'h0C; rom[2] = 8'hE7; rom[3] = 8'h30; rom[4] = 8'hE7;
    run_instrs(2, 1'b1);
    checks++;
    if (dbg_a !== 4'h1 || dbg_carry !== 1'b1 || rom_addr !== 4'h2) begin
      errors++;
      $display("[TB] FAIL add_carry: a=%h c=%b pc=%h expected a=1 c=1 pc=2", dbg_a, dbg_carry, rom_addr);
    end
    run_instrs(1, 1'b1);
    checks++;
    if (rom_addr !== 4'h3 || dbg_carry !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jnc_not_taken: pc=%h c=%b expected pc=3 c=0", rom_addr, dbg_carry);
    end
    run_instrs(2, 1'b1);
    checks++;
    if (rom_addr !== 4'h7) begin
      errors++;
      $display("[TB] FAIL jnc_taken: pc=%h expected 7", rom_addr);
    end
  endtask

  task automatic test_step();
    do_reset();
    fill_rom(8'h80);
    rom[0] = 8'hB9;
    step = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL step_fetch_busy: busy=%b expected 1", busy);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL step_exec_busy: busy=%b expected 1", busy);
    end
    model_exec(rom[m_pc], in_port);
    tick();
    checks++;
    if (busy !== 1'b0 || out_port !== 4'h9 || dut_vec() !== model_vec()) begin
      errors++;
      $display("[TB] FAIL step_done: state=%h busy=%b expected %h busy=0", dut_vec(), busy, model_vec());
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || rom_addr !== 4'h1) begin
      errors++;
      $display("[TB] FAIL step_dropped: busy=%b pc=%h expected busy=0 pc=1", busy, rom_addr);
    end
  endtask

  task automatic test_halt();
    logic [17:0] held;
    do_reset();
    fill_rom(8'h80);
    rom[0] = 8'hF3;
    rom[3] = 8'hF3;
    run_instrs(4, 1'b0);
    checks++;
    if (halted !== 1'b1 || rom_addr !== 4'h3 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_enter: halted=%b pc=%h busy=%b expected 1 3 0", halted, rom_addr, busy);
    end
    held = model_vec();
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step = k[0];
      tick();
    end
    run  = 1'b0;
    step = 1'b0;
    checks++;
    if (dut_vec() !== held || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_sticky: state=%h busy=%b expected %h busy=0", dut_vec(), busy, held);
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || rom_addr !== 4'h0) begin
      errors++;
      $display("[TB] FAIL halt_reset: halted=%b pc=%h expected 0 0", halted, rom_addr);
    end
  endtask

  task automatic test_in_out_wrap();
    do_reset();
    fill_rom(8'h80);
    in_port = 4'hA;
    rom[0] = 8'h60; rom[1] = 8'h90; rom[2] = 8'hFF; rom[15] = 8'h00;
    run_instrs(4, 1'b0);
    checks++;
    if (out_port !== 4'hA || rom_addr !== 4'h0) begin
      errors++;
      $display("[TB] FAIL in_out_wrap: out=%h pc=%h expected out=a pc=0", out_port, rom_addr);
    end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    fill_rom(8'h80);
    rom[0] = 8'hB5;
    rom[1] = 8'h3F;
    step_instr(1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    checks++;
    if (dut_vec() !== 18'h0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_exec: state=%h busy=%b expected 00000 busy=0", dut_vec(), busy);
    end
    tick();
    checks++;
    if (dut_vec() !== 18'h0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_then_idle: state=%h busy=%b expected 00000 busy=0", dut_vec(), busy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      do_reset();
      for (int k = 0; k < 16; k++) rom[k] = 8'($urandom_range(0, 255));
      for (int j = 0; j < 6; j++) begin
        if (m_halt) break;
        if ($urandom_range(0, 1) == 1) run_instrs(int'($urandom_range(1, 6)), 1'b1);
        else                           step_instr(1'b1);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    run     = 1'b0;
    step    = 1'b0;
    in_port = 4'h0;
    fill_rom(8'h80);
    model_reset();
    test_reset();
    test_add_carry();
    test_step();
    test_halt();
    test_in_out_wrap();
    test_reset_mid_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
